// File: rtl/dnn_pkg.sv
// dnn_pkg: shared definitions for the dnn_fc2_seq inference engine.
//   - state_e       : controller state encoding (IDLE, L1, L2, DONE)
//   - hw_width      : width of a hidden-layer value
//   - aw_width      : width of the output-layer accumulator
//   - cnt_width     : index counter width for a given bound (minimum 1)
//   - conv_out      : accumulator-to-output conversion; it saturates when
//                     DNN_FC2_SAT_EN is defined and wraps otherwise
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int hw_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in);
  endfunction

  function automatic int aw_width(input int dw, input int n_in, input int n_hid);
    return hw_width(dw, n_in) + dw + $clog2(n_hid);
  endfunction

  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

  // Maps a sign-extended accumulator value into the ow-bit signed range.
  // The caller keeps the low ow bits of the result.
  function automatic logic signed [63:0] conv_out(input logic signed [63:0] v,
                                                  input int ow);
`ifdef DNN_FC2_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
`else
    // Two's-complement wrap: keep ow LSBs, sign-extend from bit ow-1.
    return (v <<< (64 - ow)) >>> (64 - ow);
`endif
  endfunction

endpackage

// File: rtl/dnn_fc2_seq_if.sv
// dnn_fc2_seq_if: operand-side and result-side handshake bundle.
//   in_valid/in_ready + x, w1, w2 : operand bundle from the feature/weight source
//   out_valid/out_ready + out      : results to the classifier-output consumer
// modport slave is used by the engine, modport master by the driving side.
interface dnn_fc2_seq_if #(
  parameter int DW    = 5,
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int OW    = 17
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*DW-1:0]        x;
  logic [N_IN*N_HID*DW-1:0]  w1;
  logic [N_HID*N_OUT*DW-1:0] w2;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_OUT*OW-1:0]       out;

  modport master (
    output in_valid, x, w1, w2, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, x, w1, w2, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/dnn_mac_unit.sv
// dnn_mac_unit: signed multiply-accumulate.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : start a fresh sum (with en: acc <= a*b; alone: acc <= 0)
//   en         : accumulate a*b this cycle
//   a, b       : signed operands (AW_A and BW bits)
//   acc        : registered accumulator
//   sum        : combinational value acc will take if en is high
module dnn_mac_unit #(
  parameter int AW_A = 12,
  parameter int BW   = 5,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW_A-1:0] a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc,
  output logic signed [ACCW-1:0] sum
);
  localparam int PW = AW_A + BW;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] base;

  assign prod = PW'(a) * PW'(b);
  assign base = clr ? '0 : acc;
  assign sum  = base + ACCW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (en)  acc <= sum;
    else if (clr) acc <= '0;
  end
endmodule

// File: rtl/dnn_fc2_seq.sv
// dnn_fc2_seq: two-layer fully-connected inference engine
// (N_IN -> N_HID with ReLU -> N_OUT) on one shared, time-multiplexed MAC.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any job in flight
//   bus   : dnn_fc2_seq_if.slave (operand and result handshakes)
// Build option: define DNN_FC2_SAT_EN to saturate outputs instead of wrapping.
module dnn_fc2_seq
  import dnn_pkg::*;
#(
  parameter int DW    = 5,
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int OW    = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  dnn_fc2_seq_if.slave  bus
);
  localparam int HW   = hw_width(DW, N_IN);
  localparam int AW   = aw_width(DW, N_IN, N_HID);
  localparam int IW   = cnt_width(N_IN);
  localparam int HCW  = cnt_width(N_HID);
  localparam int OCW  = cnt_width(N_OUT);
  localparam int W1N  = N_IN * N_HID;
  localparam int W2N  = N_HID * N_OUT;
  localparam int W1IW = cnt_width(W1N);
  localparam int W2IW = cnt_width(W2N);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_L1   = L1;
  localparam logic [1:0] ST_L2   = L2;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IW-1:0]  I_LAST = IW'(N_IN - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(N_HID - 1);
  localparam logic [OCW-1:0] O_LAST = OCW'(N_OUT - 1);
  localparam logic signed [AW-1:0] ACC_ZERO = '0;

  logic [1:0]     state;
  logic [IW-1:0]  i_cnt;
  logic [HCW-1:0] h_cnt;
  logic [OCW-1:0] o_cnt;
  logic           tail;      // last output group summed, its write-back pending
  logic           out_valid_r;

  logic signed [DW-1:0] x_in  [N_IN];
  logic signed [DW-1:0] w1_in [W1N];
  logic signed [DW-1:0] w2_in [W2N];
  logic signed [DW-1:0] x_r   [N_IN];
  logic signed [DW-1:0] w1_r  [W1N];
  logic signed [DW-1:0] w2_r  [W2N];
  logic signed [HW-1:0] hidden [N_HID];
  logic signed [OW-1:0] out_r  [N_OUT];

  logic                 mac_en;
  logic                 mac_clr;
  logic signed [HW-1:0] mac_a;
  logic signed [DW-1:0] mac_b;
  logic signed [AW-1:0] mac_acc;
  logic signed [AW-1:0] mac_sum;

  logic [W1IW-1:0]      w1_idx;
  logic [W2IW-1:0]      w2_idx;
  logic [OCW-1:0]       o_prev;
  logic signed [HW-1:0] hidden_next;
  logic signed [OW-1:0] out_conv;

  // Unpacked views of the flat operand ports.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
    assign x_in[gi] = bus.x[gi*DW +: DW];
  end
  for (genvar gi = 0; gi < W1N; gi++) begin : g_w1
    assign w1_in[gi] = bus.w1[gi*DW +: DW];
  end
  for (genvar gi = 0; gi < W2N; gi++) begin : g_w2
    assign w2_in[gi] = bus.w2[gi*DW +: DW];
  end
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign bus.out[gi*OW +: OW] = out_r[gi];
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_r;

  assign w1_idx      = W1IW'(int'(h_cnt) * N_IN + int'(i_cnt));
  assign w2_idx      = W2IW'(int'(o_cnt) * N_HID + int'(h_cnt));
  assign o_prev      = o_cnt - OCW'(1);
  assign hidden_next = (mac_sum < ACC_ZERO) ? '0 : HW'(mac_sum);
  assign out_conv    = OW'(conv_out(64'(mac_acc), OW));

  // Operand steering; the first term of every group restarts the sum.
  always_comb begin
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state)
      ST_L1: begin
        mac_en  = 1'b1;
        mac_clr = (i_cnt == '0);
        mac_a   = HW'(x_r[i_cnt]);
        mac_b   = w1_r[w1_idx];
      end
      ST_L2: begin
        if (!tail) begin
          mac_en  = 1'b1;
          mac_clr = (h_cnt == '0);
          mac_a   = hidden[h_cnt];
          mac_b   = w2_r[w2_idx];
        end
      end
      default: ;
    endcase
  end

  dnn_mac_unit #(
    .AW_A (HW),
    .BW   (DW),
    .ACCW (AW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (mac_acc),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      i_cnt       <= '0;
      h_cnt       <= '0;
      o_cnt       <= '0;
      tail        <= 1'b0;
      out_valid_r <= 1'b0;
      x_r         <= '{default: '0};
      w1_r        <= '{default: '0};
      w2_r        <= '{default: '0};
      hidden      <= '{default: '0};
      out_r       <= '{default: '0};
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_r   <= x_in;
            w1_r  <= w1_in;
            w2_r  <= w2_in;
            i_cnt <= '0;
            h_cnt <= '0;
            o_cnt <= '0;
            state <= ST_L1;
          end
        end
        ST_L1: begin
          if (i_cnt == I_LAST) begin
            i_cnt         <= '0;
            hidden[h_cnt] <= hidden_next;
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              state <= ST_L2;
            end else begin
              h_cnt <= h_cnt + HCW'(1);
            end
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
        ST_L2: begin
          // Each output is written from the registered accumulator one cycle
          // after its group ends, overlapping the next group's first term;
          // the final group needs one extra (tail) cycle.
          if (tail) begin
            out_r[O_LAST] <= out_conv;
            tail          <= 1'b0;
            out_valid_r   <= 1'b1;
            state         <= ST_DONE;
          end else begin
            if (h_cnt == '0 && o_cnt != '0) out_r[o_prev] <= out_conv;
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              if (o_cnt == O_LAST) begin
                o_cnt <= '0;
                tail  <= 1'b1;
              end else begin
                o_cnt <= o_cnt + OCW'(1);
              end
            end else begin
              h_cnt <= h_cnt + HCW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dnn_fc2_seq.sv
// tb_dnn_fc2_seq: self-checking bench for dnn_fc2_seq.
// Two engines share one operand/result handshake: the default OW=17 build and
// an OW=12 build that exercises the wrap/saturate output conversion
// (expected values follow DNN_FC2_SAT_EN when it is defined).
module tb_dnn_fc2_seq;
  localparam int DW    = 5;
  localparam int N_IN  = 4;
  localparam int N_HID = 4;
  localparam int N_OUT = 2;
  localparam int OW    = 17;
  localparam int OWS   = 12;
  localparam int XW    = N_IN * DW;
  localparam int W1W   = N_IN * N_HID * DW;
  localparam int W2W   = N_HID * N_OUT * DW;
  localparam int LAT   = N_IN * N_HID + N_HID * N_OUT + 1;

`ifdef DNN_FC2_SAT_EN
  localparam int S_MAX15 = 2047;
  localparam int S_MIN16 = -2048;
`else
  localparam int S_MAX15 = 752;
  localparam int S_MIN16 = 0;
`endif

  typedef struct {
    int o0;
    int o1;
    int s0;
    int s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dnn_fc2_seq_if #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .OW(OW))  bus ();
  dnn_fc2_seq_if #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .OW(OWS)) bus_s ();

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.x         = bus.x;
  assign bus_s.w1        = bus.w1;
  assign bus_s.w2        = bus.w2;
  assign bus_s.out_ready = bus.out_ready;

  dnn_fc2_seq #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .OW(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dnn_fc2_seq #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .OW(OWS)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  int xs  [N_IN];
  int w1s [N_HID][N_IN];
  int w2s [N_OUT][N_HID];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  function automatic int out0();
    logic signed [OW-1:0] t;
    t = bus.out[0 +: OW];
    return int'(t);
  endfunction
  function automatic int out1();
    logic signed [OW-1:0] t;
    t = bus.out[OW +: OW];
    return int'(t);
  endfunction
  function automatic int outs0();
    logic signed [OWS-1:0] t;
    t = bus_s.out[0 +: OWS];
    return int'(t);
  endfunction
  function automatic int outs1();
    logic signed [OWS-1:0] t;
    t = bus_s.out[OWS +: OWS];
    return int'(t);
  endfunction

  task automatic fill_all(input int v);
    for (int i = 0; i < N_IN; i++) xs[i] = v;
    for (int h = 0; h < N_HID; h++) for (int i = 0; i < N_IN; i++) w1s[h][i] = v;
    for (int o = 0; o < N_OUT; o++) for (int h = 0; h < N_HID; h++) w2s[o][h] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_IN; i++) xs[i] = $urandom_range(31) - 16;
    for (int h = 0; h < N_HID; h++) for (int i = 0; i < N_IN; i++) w1s[h][i] = $urandom_range(31) - 16;
    for (int o = 0; o < N_OUT; o++) for (int h = 0; h < N_HID; h++) w2s[o][h] = $urandom_range(31) - 16;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N_IN; i++) bus.x[i*DW +: DW] = DW'(xs[i]);
    for (int h = 0; h < N_HID; h++)
      for (int i = 0; i < N_IN; i++) bus.w1[(h*N_IN+i)*DW +: DW] = DW'(w1s[h][i]);
    for (int o = 0; o < N_OUT; o++)
      for (int h = 0; h < N_HID; h++) bus.w2[(o*N_HID+h)*DW +: DW] = DW'(w2s[o][h]);
  endtask

  task automatic scramble();
    bus.x  = XW'($urandom);
    bus.w1 = W1W'({$urandom, $urandom, $urandom});
    bus.w2 = W2W'({$urandom, $urandom});
  endtask

  // Reference: integer arithmetic, ReLU on the hidden layer, then the
  // OW=12 conversion (clamp or keep 12 LSBs).
  function automatic int to_s12(input int v);
    logic signed [OWS-1:0] t;
`ifdef DNN_FC2_SAT_EN
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
`else
    t = v[OWS-1:0];
    return int'(t);
`endif
  endfunction

  function automatic exp_t model();
    int   hid [N_HID];
    int   acc [N_OUT];
    exp_t e;
    for (int h = 0; h < N_HID; h++) begin
      hid[h] = 0;
      for (int i = 0; i < N_IN; i++) hid[h] += xs[i] * w1s[h][i];
      if (hid[h] < 0) hid[h] = 0;
    end
    for (int o = 0; o < N_OUT; o++) begin
      acc[o] = 0;
      for (int h = 0; h < N_HID; h++) acc[o] += hid[h] * w2s[o][h];
    end
    e.o0 = acc[0];
    e.o1 = acc[1];
    e.s0 = to_s12(acc[0]);
    e.s1 = to_s12(acc[1]);
    return e;
  endfunction

  // One job: accept, latency, optional backpressure hold, result, hand-back.
  task automatic run_job(input string name, input exp_t e, input bit pre_ready,
                         input int hold, input bit glitch);
    int   lat;
    int   snap0;
    int   snap1;
    exp_t ex;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "/idle_ready"}, 64'(bus.in_ready), 64'(1));
    bus.out_ready = pre_ready;
    drive_ops();
    bus.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (glitch) bus.in_valid = (lat == 5);
      if (glitch && lat == 5) scramble();
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check({name, "/latency"}, 64'(lat), 64'(LAT));
    check({name, "/busy_in_ready"}, 64'(bus.in_ready), 64'(0));
    check({name, "/s_out_valid"}, 64'(bus_s.out_valid), 64'(1));
    if (!pre_ready) begin
      snap0 = out0();
      snap1 = out1();
      repeat (hold) begin
        @(posedge clk); #1;
      end
      check({name, "/hold_out_valid"}, 64'(bus.out_valid), 64'(1));
      check({name, "/hold_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({name, "/hold_out0"}, 64'(out0()), 64'(snap0));
      check({name, "/hold_out1"}, 64'(out1()), 64'(snap1));
      bus.out_ready = 1'b1;
    end
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      check({name, "/out0"}, 64'(out0()), 64'(ex.o0));
      check({name, "/out1"}, 64'(out1()), 64'(ex.o1));
      check({name, "/out12_0"}, 64'(outs0()), 64'(ex.s0));
      check({name, "/out12_1"}, 64'(outs1()), 64'(ex.s1));
    end else begin
      check({name, "/scoreboard_empty"}, 64'(sb.size()), 64'(1));
    end
    $display("job %-10s out0=%0d out1=%0d out12_0=%0d out12_1=%0d latency=%0d",
             name, out0(), out1(), outs0(), outs1(), lat);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "/taken_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({name, "/taken_in_ready"}, 64'(bus.in_ready), 64'(1));
    check({name, "/kept_out0"}, 64'(out0()), 64'(ex.o0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x  = '0;
    bus.w1 = '0;
    bus.w2 = '0;

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(bus.in_ready), 64'(1));
    check("reset/out_valid", 64'(bus.out_valid), 64'(0));
    check("reset/out", 64'(bus.out), 64'(0));
    check("reset/out12", 64'(bus_s.out), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed signs, out_ready already high when results appear.
    xs  = '{4, 2, 4, 1};
    w1s = '{'{3, 2, 13, -6}, '{-9, 1, -4, 14}, '{3, 6, -15, 15}, '{9, -10, 15, -10}};
    w2s = '{'{0, -1, 3, -11}, '{-12, -15, -15, 6}};
    e = '{o0: -726, o1: -348, s0: -726, s1: -348};
    run_job("mixed", e, 1'b1, 0, 1'b0);

    // All minimum.
    fill_all(-16);
    e = '{o0: -65536, o1: -65536, s0: S_MIN16, s1: S_MIN16};
    run_job("all_min", e, 1'b0, 0, 1'b0);

    // All maximum.
    fill_all(15);
    e = '{o0: 54000, o1: 54000, s0: S_MAX15, s1: S_MAX15};
    run_job("all_max", e, 1'b0, 2, 1'b0);

    // Backpressure hold and a stray in_valid pulse during L1.
    fill_random();
    e = model();
    run_job("busy_bp", e, 1'b0, 10, 1'b1);

    // Reset asserted in L2 aborts the job at once.
    fill_all(15);
    drive_ops();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort/out_valid", 64'(bus.out_valid), 64'(0));
    check("abort/out", 64'(bus.out), 64'(0));
    check("abort/out12", 64'(bus_s.out), 64'(0));
    check("abort/in_ready", 64'(bus.in_ready), 64'(1));
    $display("job %-10s reset during L2", "abort");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Re-run after reset.
    fill_all(15);
    e = '{o0: 54000, o1: 54000, s0: S_MAX15, s1: S_MAX15};
    run_job("rerun_max", e, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dnn_fc2_seq.md
Name: dnn_fc2_seq

Overview:
- Parametrised successor to the fixed 4-4-2 DNN multiplier block.
- Two-layer fully-connected inference engine: N_IN inputs → N_HID hidden neurons with ReLU → N_OUT outputs.
- Signed DW-bit operands; one shared MAC, time-multiplexed; valid/ready handshakes on both sides.
- Sits between the feature/weight source and the classifier-output consumer.

Parameters:
- DW, 5, signed input and weight width.
- N_IN, 4, input count.
- N_HID, 4, hidden neuron count.
- N_OUT, 2, output count.
- OW, 17, signed output width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block idle and able to accept.
- x  in  N_IN*DW  input i at [i*DW +: DW].
- w1  in  N_IN*N_HID*DW  weight input i → hidden h at [(h*N_IN+i)*DW +: DW].
- w2  in  N_HID*N_OUT*DW  weight hidden h → output o at [(o*N_HID+h)*DW +: DW].
- out_valid  out  1  results valid; held until accepted.
- out_ready  in  1  consumer accepts results.
- out  out  N_OUT*OW  output o at [o*OW +: OW].

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out=0; hidden and accumulator registers cleared. Reset asserted mid-computation aborts the computation with no partial output.
- Internal widths:
  - HW = 2*DW + clog2(N_IN) for hidden values.
  - AW = HW + DW + clog2(N_HID) for output accumulation.
  - No internal overflow is possible.
- FSM states: IDLE, L1, L2, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid=1: capture x, w1, w2 into registers and go to L1.
  - Inputs are ignored at all other times; later changes to the input ports do not affect the result.
- L1:
  - N_IN*N_HID cycles, one product x[i]*w1[h,i] per cycle; i is the inner index.
  - After the N_IN-th term of neuron h, store hidden[h] = max(acc, 0) (ReLU), then clear the accumulator.
- L2:
  - N_HID*N_OUT cycles, one product hidden[h]*w2[o,h] per cycle; h is the inner index.
  - After each group, write out[o] through the output conversion.
  - After the last group, go to DONE.
- DONE:
  - out_valid=1; out stable.
  - On the edge where out_ready=1: go to IDLE and drop out_valid. out keeps its value until the next write.
  - in_ready=0 in DONE. No overlap of a new job with an unaccepted result.
- Latency: out_valid rises exactly N_IN*N_HID + N_HID*N_OUT + 1 edges after the accepting edge (25 with defaults).
- If out_ready is already high when out_valid rises: result is consumed on the next edge, and in_ready returns 1 one cycle after that.
- Output conversion, default: AW result truncated to OW LSBs (two's-complement wrap).
- Counters: i, h and o counters wrap to 0 at their bounds. Counter width is clog2 of the bound, minimum 1.

Optional Feature:
- Macro DNN_FC2_SAT_EN.
- When defined: output conversion saturates to [-2^(OW-1), 2^(OW-1)-1] instead of wrapping.
- When undefined: plain truncation.
- All other behaviour is identical in both builds.

Decomposition:
- Package dnn_pkg:
  - state enum type (IDLE, L1, L2, DONE).
  - width helper functions for HW and AW.
  - sat/wrap conversion function, guarded by DNN_FC2_SAT_EN.
- Sub-module dnn_mac_unit: signed multiply-accumulate with synchronous clear and enable, parametrised on operand and accumulator width; instantiated once.

Test Plan (defaults unless stated; operands are 5-bit two's complement):
1. Mixed sign.
   - Stimulus: x=[4,2,4,1]; w1 rows h0=[3,2,13,-6], h1=[-9,1,-4,14], h2=[3,6,-15,15], h3=[9,-10,15,-10]; w2 o0=[0,-1,3,-11], o1=[-12,-15,-15,6].
   - Required: out0=-726, out1=-348; out_valid exactly 25 edges after accept.
   - Without ReLU out0 would be -753, so this test proves ReLU is applied.
2. All minimum: all operands -16 → out0 = out1 = -65536.
3. All maximum: all operands 15 → out0 = out1 = 54000.
4. OW=12, all operands 15:
   - Wrap build: out=752.
   - DNN_FC2_SAT_EN build: out=2047.
   - With all operands -16 instead: wrap build out=0; sat build out=-2048.
5. Backpressure and busy:
   - Hold out_ready=0 for 10 cycles after out_valid; out stays stable and in_ready stays 0.
   - A second in_valid pulse during L1 is ignored and the result is unchanged.
6. Reset and re-run:
   - Assert rst_n=0 during L2; out_valid=0 and out=0 immediately (asynchronously).
   - Then rerun test 3 and get 54000 on both outputs.
